mv_stream_loader: RTL and testbench
===================================

MV_STREAM_LOADER -- requirements
Module: mv_stream_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, stream word width in bits.
REQ-002 SHALL have parameter MTX_PER_WORD, default WORD_W/2, ternary matrix elements packed per stream word.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_dst in 2: load command handshake; dst 0=V0, 1=V1, 2=M0, 3=reserved.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in WORD_W, s_last in 1: payload stream.
REQ-007 SHALL have port mv_out  out  mv_t  assembled operand, driving mtx_unit in.
REQ-008 SHALL have port vliw_inst  out  vliw_inst_t  load instruction to mtx_unit.
REQ-009 SHALL have ports issue_valid out 1, issue_ready in 1: issue handshake toward downstream controller.
REQ-010 SHALL have ports busy out 1 (state != IDLE) and err out 1 (sticky error flag).

Function
REQ-011 SHALL implement states IDLE, FILL, ISSUE, DRAIN.
REQ-012 IDLE: cmd_ready=1; on cmd_valid with dst 0..2, latch dst, clear word counter, go FILL; dst 3 sets err, stays IDLE.
REQ-013 FILL: s_ready=1; each s_valid&&s_ready accepts one word.
REQ-014 Vector load: word k (0..V-1) stored unmodified in mv_out.vec.vec[k]; expected length V words.
REQ-015 Matrix load: word k bits [2j+1:2j] map to element index n=k*MTX_PER_WORD+j, row n/C, column n%C; expected length ceil(R*C/MTX_PER_WORD) words; surplus bits of last word ignored.
REQ-016 Counter reaching expected length on acceptance moves FILL->ISSUE next cycle.
REQ-017 ISSUE: issue_valid=1, vliw_inst.op1 = LD_V0/LD_V1/LD_M0 per dst, op2..op4 = NOP; mv_out held stable.
REQ-018 Issue transfer on issue_valid&&issue_ready; next state IDLE; vliw_inst returns to all-NOP same edge.
REQ-019 Outside ISSUE vliw_inst SHALL be all-NOP and issue_valid 0; s_ready 0 outside FILL/DRAIN; cmd_ready 0 outside IDLE.
REQ-020 Latency: last word accepted cycle t -> issue_valid high cycle t+1; minimum command-to-issue V+1 cycles with no stalls.
REQ-021 mv_out SHALL retain last assembled value in IDLE; a new load overwrites only the fields it writes.
REQ-022 err cleared only by reset or by a cmd handshake with valid dst.

Reset
REQ-023 rst_n low asynchronously forces IDLE, counter 0, mv_out 0, vliw_inst all-NOP, issue_valid 0, s_ready 0, cmd_ready 0 during reset, err 0, busy 0.
REQ-024 Reset mid-FILL or mid-ISSUE SHALL abandon the load with no instruction issued after release.

Configuration
REQ-025 Macro MV_STREAM_LOADER_LAST_CHECK_EN defined: s_last on a word before the expected final word sets err and goes IDLE (no issue); expected final word without s_last sets err and goes DRAIN, discarding words until s_last accepted, then IDLE (no issue).
REQ-026 Macro undefined: s_last ignored; length purely counter-driven; DRAIN unreachable.

Structure
REQ-027 Command destination enum (DST_V0, DST_V1, DST_M0) and state enum SHALL live in mtx_types alongside mv_t, vliw_inst_t, V, R, C, PLUS/ZERO/MINUS.
REQ-028 One sub-module natural: mv_ternary_unpack (combinational word->element-slice mapper); no other hierarchy.

Verification
REQ-029 cmd dst=0, V words 0x4000_0000+(i<<24), s_last on final -> issue_valid at t+1, op1=LD_V0, mv_out.vec.vec[3]=0x4300_0000.
REQ-030 cmd dst=2, words encoding (r+c)%3 pattern -> op1=LD_M0, data3[0][0]=PLUS, data3[0][1]=ZERO, data3[0][2]=MINUS.
REQ-031 issue_ready held 0 for 5 cycles in ISSUE -> issue_valid, vliw_inst, mv_out stable; s_ready 0; transfer on cycle 6.
REQ-032 cmd dst=3 -> err=1, state IDLE; next valid cmd clears err.
REQ-033 LAST_CHECK_EN: s_last on word 2 of vector load -> err=1, no issue_valid; missing s_last -> DRAIN until s_last, then IDLE.
REQ-034 rst_n pulsed low mid-FILL (word 3) -> all outputs at reset values immediately; no issue after release.

Source files
------------

// File: rtl/mv_stream_loader_pkg.sv
// Shared operand/instruction types for the matrix-vector loader and mtx_unit.
// Ternary codes: ZERO=00, PLUS=01, MINUS=11 (10 unused).
package mtx_types;

  localparam int MV_WORD_W = 32;
  localparam int V = 4;
  localparam int R = 3;
  localparam int C = 8;

  typedef logic [1:0] trit_t;
  localparam trit_t ZERO  = 2'b00;
  localparam trit_t PLUS  = 2'b01;
  localparam trit_t MINUS = 2'b11;

  typedef enum logic [1:0] {
    DST_V0 = 2'd0,
    DST_V1 = 2'd1,
    DST_M0 = 2'd2
  } dst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    LD_V0 = 3'd1,
    LD_V1 = 3'd2,
    LD_M0 = 3'd3
  } op_t;

  typedef struct packed {
    op_t op1;
    op_t op2;
    op_t op3;
    op_t op4;
  } vliw_inst_t;

  localparam vliw_inst_t VLIW_NOP = '{NOP, NOP, NOP, NOP};

  typedef struct packed {
    logic [V-1:0][MV_WORD_W-1:0] vec;
  } vec_t;

  // Element n = r*C + c sits at bits [2n+1:2n] of the flattened matrix.
  typedef trit_t [R-1:0][C-1:0] mtx_t;

  typedef struct packed {
    vec_t vec;
    mtx_t data3;
  } mv_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mv_stream_loader_if.sv
// Command, payload stream, operand and issue signals of the loader.
// slave = loader side, master = command/stream source and issue sink.
interface mv_stream_loader_if
  import mtx_types::*;
#(
  parameter int WORD_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_dst;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  mv_t               mv_out;
  vliw_inst_t        vliw_inst;
  logic              issue_valid;
  logic              issue_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_dst, s_valid, s_data, s_last, issue_ready,
    output cmd_ready, s_ready, mv_out, vliw_inst, issue_valid, busy, err
  );

  modport master (
    output cmd_valid, cmd_dst, s_valid, s_data, s_last, issue_ready,
    input  cmd_ready, s_ready, mv_out, vliw_inst, issue_valid, busy, err
  );

endinterface

// File: rtl/mv_stream_loader_unpack.sv
// Combinational mapper: overlays the ternary elements carried by stream word
// word_idx onto the current matrix; elements past R*C are dropped.
module mv_ternary_unpack
  import mtx_types::*;
#(
  parameter int WORD_W       = 32,
  parameter int MTX_PER_WORD = WORD_W / 2,
  parameter int IDX_W        = 3
) (
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  word_idx,
  input  mtx_t              mtx_in,
  output mtx_t              mtx_out
);

  always_comb begin
    mtx_out = mtx_in;
    for (int n = 0; n < R * C; n++) begin
      if (IDX_W'(n / MTX_PER_WORD) == word_idx) begin
        mtx_out[n / C][n % C] = word[2 * (n % MTX_PER_WORD) +: 2];
      end
    end
  end

endmodule

// File: rtl/mv_stream_loader.sv
// Streams vector/matrix operands into mv_out and issues one load instruction.
// Optional macro MV_STREAM_LOADER_LAST_CHECK_EN enables s_last framing checks.
//
//   state | meaning
//   IDLE  | waiting for a load command
//   FILL  | accepting payload words into mv_out
//   ISSUE | load instruction presented until issue_ready
//   DRAIN | discarding words of a mis-framed load until s_last
module mv_stream_loader
  import mtx_types::*;
#(
  parameter int WORD_W       = 32,
  parameter int MTX_PER_WORD = WORD_W / 2
) (
  input logic               clk,
  input logic               rst_n,
  mv_stream_loader_if.slave bus
);

  localparam int M_LEN   = ceil_div(R * C, MTX_PER_WORD);
  localparam int MAX_LEN = (V > M_LEN) ? V : M_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int VI_W    = (V > 1) ? $clog2(V) : 1;
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V - 1);
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(M_LEN - 1);

  state_t           state_q, state_d;
  dst_t             dst_q;
  logic [CNT_W-1:0] cnt_q;
  mv_t              mv_q;
  mtx_t             mtx_next;
  logic             err_q;
  logic             run_q;

  logic       cmd_ready, s_ready, issue_valid;
  vliw_inst_t vliw;
  logic       cmd_hs, cmd_ok, s_acc, at_last;

  assign cmd_hs  = bus.cmd_valid && cmd_ready;
  assign cmd_ok  = (bus.cmd_dst != 2'd3);
  assign s_acc   = bus.s_valid && s_ready;
  assign at_last = (cnt_q == ((dst_q == DST_M0) ? M_LAST : V_LAST));

  mv_ternary_unpack #(
    .WORD_W       (WORD_W),
    .MTX_PER_WORD (MTX_PER_WORD),
    .IDX_W        (CNT_W)
  ) u_unpack (
    .word     (bus.s_data),
    .word_idx (cnt_q),
    .mtx_in   (mv_q.data3),
    .mtx_out  (mtx_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_hs && cmd_ok) state_d = FILL;
      FILL: begin
        if (s_acc) begin
`ifdef MV_STREAM_LOADER_LAST_CHECK_EN
          if (at_last)           state_d = bus.s_last ? ISSUE : DRAIN;
          else if (bus.s_last)   state_d = IDLE;
`else
          if (at_last)           state_d = ISSUE;
`endif
        end
      end
      ISSUE: if (bus.issue_ready) state_d = IDLE;
      DRAIN: if (s_acc && bus.s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready waits for run_q so it stays low while rst_n is asserted.
  always_comb begin
    cmd_ready   = run_q && (state_q == IDLE);
    s_ready     = (state_q == FILL) || (state_q == DRAIN);
    issue_valid = (state_q == ISSUE);
    vliw        = VLIW_NOP;
    if (state_q == ISSUE) begin
      case (dst_q)
        DST_V0:  vliw.op1 = LD_V0;
        DST_V1:  vliw.op1 = LD_V1;
        default: vliw.op1 = LD_M0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q <= DST_V0;
      cnt_q <= '0;
      mv_q  <= '0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (cmd_hs) begin
        if (cmd_ok) begin
          err_q <= 1'b0;
          dst_q <= dst_t'(bus.cmd_dst);
          cnt_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (s_acc) cnt_q <= cnt_q + CNT_W'(1);
      if (s_acc && (state_q == FILL)) begin
        if (dst_q == DST_M0) mv_q.data3 <= mtx_next;
        else mv_q.vec.vec[cnt_q[VI_W-1:0]] <= MV_WORD_W'(bus.s_data);
`ifdef MV_STREAM_LOADER_LAST_CHECK_EN
        if (at_last != bus.s_last) err_q <= 1'b1;
`endif
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.s_ready     = s_ready;
  assign bus.issue_valid = issue_valid;
  assign bus.vliw_inst   = vliw;
  assign bus.mv_out      = mv_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mv_stream_loader.sv
// Directed bench for mv_stream_loader: vector/matrix loads, issue stalls,
// bad destination, s_last handling for the active build, and mid-load reset.
module tb_mv_stream_loader;
  import mtx_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [47:0] MTX_EXP = 48'h71C7_C71C_1C71;

  vliw_inst_t exp_v;

  mv_stream_loader_if #(.WORD_W(32)) bus ();

  mv_stream_loader #(
    .WORD_W       (32),
    .MTX_PER_WORD (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge; one rising edge in between.
  task automatic send_cmd(input logic [1:0] dst);
    bus.cmd_valid = 1'b1;
    bus.cmd_dst   = dst;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_issue();
    bus.issue_ready = 1'b1;
    @(negedge clk);
    bus.issue_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_dst     = 2'd0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.issue_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_mv_out", bus.mv_out, 0);
    check("rst_vliw", bus.vliw_inst, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // vector load to V0
    send_cmd(2'd0);
    check("v0_busy", bus.busy, 1);
    check("v0_s_ready", bus.s_ready, 1);
    check("v0_cmd_ready", bus.cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      send_word(32'(32'h4000_0000 + (i << 24)), (i == 3));
      if (i < 3) check("v0_fill_no_issue", bus.issue_valid, 0);
    end
    exp_v = VLIW_NOP;
    exp_v.op1 = LD_V0;
    check("v0_issue_valid", bus.issue_valid, 1);
    check("v0_vliw", bus.vliw_inst, exp_v);
    check("v0_vec3", bus.mv_out.vec.vec[3], 32'h4300_0000);
    check("v0_vec0", bus.mv_out.vec.vec[0], 32'h4000_0000);
    check("v0_issue_s_ready", bus.s_ready, 0);
    do_issue();
    check("v0_after_iv", bus.issue_valid, 0);
    check("v0_after_vliw", bus.vliw_inst, VLIW_NOP);
    check("v0_after_busy", bus.busy, 0);
    check("v0_after_vec3", bus.mv_out.vec.vec[3], 32'h4300_0000);

    // matrix load, (r+c)%3 pattern, stall mid-stream and at issue
    send_cmd(2'd2);
    send_word(32'hC71C_1C71, 1'b0);
    @(negedge clk);
    check("m0_gap_iv", bus.issue_valid, 0);
    check("m0_gap_s_ready", bus.s_ready, 1);
    send_word(32'hFFFF_71C7, 1'b1);
    exp_v = VLIW_NOP;
    exp_v.op1 = LD_M0;
    for (int k = 0; k < 5; k++) begin
      check("m0_stall_iv", bus.issue_valid, 1);
      check("m0_stall_vliw", bus.vliw_inst, exp_v);
      check("m0_stall_data3", bus.mv_out.data3, MTX_EXP);
      check("m0_stall_s_ready", bus.s_ready, 0);
      @(negedge clk);
    end
    check("m0_00", bus.mv_out.data3[0][0], PLUS);
    check("m0_01", bus.mv_out.data3[0][1], ZERO);
    check("m0_02", bus.mv_out.data3[0][2], MINUS);
    check("m0_11", bus.mv_out.data3[1][1], MINUS);
    check("m0_27", bus.mv_out.data3[2][7], PLUS);
    check("m0_keep_vec", bus.mv_out.vec.vec[3], 32'h4300_0000);
    bus.issue_ready = 1'b1;
    check("m0_c6_iv", bus.issue_valid, 1);
    @(negedge clk);
    bus.issue_ready = 1'b0;
    check("m0_done_iv", bus.issue_valid, 0);
    check("m0_done_busy", bus.busy, 0);

    // reserved destination, then recovery with V1
    send_cmd(2'd3);
    check("dst3_err", bus.err, 1);
    check("dst3_busy", bus.busy, 0);
    check("dst3_cmd_ready", bus.cmd_ready, 1);
    send_cmd(2'd1);
    check("v1_err_clr", bus.err, 0);
    check("v1_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) send_word(32'(32'h1111_0000 + i), (i == 3));
    exp_v = VLIW_NOP;
    exp_v.op1 = LD_V1;
    check("v1_vliw", bus.vliw_inst, exp_v);
    check("v1_vec0", bus.mv_out.vec.vec[0], 32'h1111_0000);
    check("v1_vec3", bus.mv_out.vec.vec[3], 32'h1111_0003);
    check("v1_keep_mtx", bus.mv_out.data3, MTX_EXP);
    do_issue();

`ifdef MV_STREAM_LOADER_LAST_CHECK_EN
    // early s_last on word 2
    send_cmd(2'd0);
    send_word(32'h5000_0000, 1'b0);
    send_word(32'h5000_0001, 1'b0);
    send_word(32'h5000_0002, 1'b1);
    check("early_err", bus.err, 1);
    check("early_busy", bus.busy, 0);
    check("early_iv", bus.issue_valid, 0);
    // missing s_last on final word
    send_cmd(2'd0);
    check("miss_err_clr", bus.err, 0);
    for (int i = 0; i < 4; i++) send_word(32'(32'h5100_0000 + i), 1'b0);
    check("miss_err", bus.err, 1);
    check("miss_busy", bus.busy, 1);
    check("miss_iv", bus.issue_valid, 0);
    check("miss_s_ready", bus.s_ready, 1);
    send_word(32'h5200_0000, 1'b0);
    check("drain_busy", bus.busy, 1);
    check("drain_iv", bus.issue_valid, 0);
    send_word(32'h5200_0001, 1'b1);
    check("drain_done_busy", bus.busy, 0);
    check("drain_done_iv", bus.issue_valid, 0);
    check("drain_cmd_ready", bus.cmd_ready, 1);
`else
    // s_last is ignored: early s_last does not end the load, missing one is fine
    send_cmd(2'd0);
    send_word(32'h5000_0000, 1'b0);
    send_word(32'h5000_0001, 1'b1);
    check("nolast_busy", bus.busy, 1);
    check("nolast_err", bus.err, 0);
    send_word(32'h5000_0002, 1'b0);
    check("nolast_iv_early", bus.issue_valid, 0);
    send_word(32'h5000_0003, 1'b0);
    exp_v = VLIW_NOP;
    exp_v.op1 = LD_V0;
    check("nolast_iv", bus.issue_valid, 1);
    check("nolast_vliw", bus.vliw_inst, exp_v);
    check("nolast_vec2", bus.mv_out.vec.vec[2], 32'h5000_0002);
    check("nolast_err2", bus.err, 0);
    do_issue();
`endif

    // reset pulsed mid-FILL on word 3
    send_cmd(2'd0);
    for (int i = 0; i < 3; i++) send_word(32'(32'h6000_0000 + i), 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h6000_0003;
    bus.s_last  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_iv", bus.issue_valid, 0);
    check("mid_rst_vliw", bus.vliw_inst, VLIW_NOP);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_mv", bus.mv_out, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_iv", bus.issue_valid, 0);
      check("post_rst_busy", bus.busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
